// File: rtl/display_pkg.sv
// display_pkg: constants shared by the 7-segment display
// capture block and the display driver side.
package display_pkg;

  localparam int SETTLE_DEF  = 8;
  localparam int TIMEOUT_DEF = 4096;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_SAMPLE,
    ST_HOLD
  } cap_state_t;

  // Active-low a..g in [6:0] (a is [6]); entry n is the glyph for hex n.
  localparam logic [15:0][6:0] GLYPH = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    return GLYPH[v];
  endfunction

  function automatic logic digit_ok(input logic [7:0] d);
    return (d[7:4] == 4'h0) && $onehot(d[3:0]);
  endfunction

endpackage

// File: rtl/seg2hex.sv
// seg2hex: maps an active-low a..g pattern back to its hex
// value; valid drops for any pattern outside the glyph table.
module seg2hex
  import display_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] num,
  output logic       valid
);

  always_comb begin
    num   = 4'h0;
    valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pat == GLYPH[i]) begin
        num   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_capture.sv
// display_capture: samples a multiplexed 7-segment display and
// reassembles the four displayed hex digits into capVal.
module display_capture
  import display_pkg::*;
#(
  parameter int SETTLE  = SETTLE_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk5,
  input  logic        reset,
  input  logic [7:0]  digit,
  input  logic [7:0]  segment,
  output logic [15:0] capVal,
  output logic        capValid,
  output logic        segError
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  cap_state_t    state;
  cap_state_t    nxt;
  logic [7:0]    d_q;
  logic [7:0]    s_q;
  logic [SW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [3:0]    mask;
  logic [3:0]    mask_b;
  logic [3:0]    mask_n;
  logic          bad;
  logic          bad_b;
  logic          done_q;
  logic [15:0]   frame_q;
  logic [15:0]   frame_n;
  logic          chg;
  logic          dchg;
  logic          samp;
  logic          expired;
  logic          full;
  logic [3:0]    hnum;
  logic          hok;

  seg2hex u_dec (
    .pat   (s_q[7:1]),
    .num   (hnum),
    .valid (hok)
  );

  assign chg     = (digit != d_q) || (segment != s_q);
  assign dchg    = digit != d_q;
  assign samp    = state == ST_SAMPLE;
  assign expired = tcnt == TW'(TIMEOUT - 1);

  always_comb begin
    nxt = state;
    unique case (state)
      ST_WAIT:
        if (!chg && digit_ok(d_q)) nxt = ST_SETTLE;
      ST_SETTLE:
        if (chg) nxt = ST_WAIT;
        else if (cnt == SW'(SETTLE - 1)) nxt = ST_SAMPLE;
      ST_SAMPLE:
        nxt = ST_HOLD;
      ST_HOLD:
        if (dchg) nxt = ST_WAIT;
      default:
        nxt = ST_WAIT;
    endcase
  end

  // An expired partial frame is dropped even if a sample lands
  // on the very cycle the timeout matures.
  always_comb begin
    mask_b  = expired ? 4'h0 : mask;
    bad_b   = expired ? 1'b0 : bad;
    mask_n  = mask_b | d_q[3:0];
    full    = mask_n == 4'hF;
    frame_n = frame_q;
    for (int i = 0; i < 4; i++) begin
      if (d_q[i] && hok) frame_n[i*4 +: 4] = hnum;
    end
  end

  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      state <= ST_WAIT;
      d_q   <= '0;
      s_q   <= '0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      d_q   <= digit;
      s_q   <= segment;
      if (chg || state != ST_SETTLE) cnt <= '0;
      else if (cnt != SW'(SETTLE - 1)) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      tcnt     <= '0;
      mask     <= '0;
      bad      <= 1'b0;
      frame_q  <= '0;
      done_q   <= 1'b0;
      segError <= 1'b0;
      capValid <= 1'b0;
      capVal   <= '0;
    end else begin
      done_q   <= samp && full && !bad_b && hok;
      segError <= samp && !hok;
      capValid <= done_q;
      if (done_q) capVal <= frame_q;
      if (samp) begin
        tcnt    <= '0;
        frame_q <= frame_n;
        mask    <= full ? 4'h0 : mask_n;
        bad     <= full ? 1'b0 : (bad_b | ~hok);
      end else if (expired) begin
        mask <= '0;
        bad  <= 1'b0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/display_capture.md
DISPLAY_CAPTURE -- requirements
Module: display_capture

Interface
REQ-001 Parameter SETTLE, default 8: cycles digit/segment must be stable before a digit is sampled.
REQ-002 Parameter TIMEOUT, default 4096: cycles without a new digit sample before the partial frame is discarded.
REQ-003 clk5  input  1  system clock (5 MHz).
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 digit  input  8  digit-select bus; [3:0] one-hot active-high (0001=nibble 0 ... 1000=nibble 3); [7:4] expected 0.
REQ-006 segment  input  8  multiplexed segment bus; [7:1]=a..g active-low; [0]=dp active-low, ignored.
REQ-007 capVal  output  16  last complete, error-free frame; nibble n from digit n.
REQ-008 capValid  output  1  one-cycle pulse when capVal updates.
REQ-009 segError  output  1  one-cycle pulse when a sampled pattern is not a legal hex glyph.

Function
REQ-010 The block SHALL register digit and segment once and compare each cycle with the previous registered value; any change SHALL reload the settle counter to 0.
REQ-011 A digit value is legal only if [7:4]=0 and [3:0] is exactly one-hot; illegal values (0000, multi-hot) SHALL hold the FSM in WAIT and sample nothing.
REQ-012 FSM states: WAIT (await legal digit), SETTLE (count stable cycles), SAMPLE (one cycle: decode, store), HOLD (await digit change).
REQ-013 WAIT->SETTLE on legal digit; SETTLE->SAMPLE when counter reaches SETTLE-1 with no input change; SETTLE->WAIT on change; SAMPLE->HOLD; HOLD->WAIT on any digit change.
REQ-014 Each digit SHALL be sampled at most once per stable interval; an unchanging digit never produces a second sample.
REQ-015 SAMPLE SHALL decode segment[7:1] via the 16-entry hex glyph table (0-9, A, b, C, d, E, F) into the nibble selected by digit and set that nibble's bit in a 4-bit frame mask.
REQ-016 An undecodable pattern SHALL pulse segError in the SAMPLE cycle's next cycle and set a frame-bad flag; its nibble is not stored.
REQ-017 When a sample sets the mask to 1111: if frame-bad is clear, capVal SHALL load the assembled 16 bits and capValid pulses on the next cycle; the mask and frame-bad SHALL then clear.
REQ-018 Mask completion is order-independent; a re-sampled nibble before completion SHALL overwrite the earlier value.
REQ-019 A timeout counter SHALL clear on each SAMPLE; at TIMEOUT-1 it SHALL clear mask and frame-bad without asserting any output; counter saturates.
REQ-020 Latency: capValid asserts 2 cycles after the SAMPLE state of the completing digit.
REQ-021 capVal SHALL hold its value between frames; capValid and segError SHALL never assert in the same cycle for the same sample.

Reset
REQ-022 On reset low: FSM=WAIT, counters=0, mask=0000, frame-bad=0, capVal=16'h0000, capValid=0, segError=0, input registers=0.
REQ-023 Reset mid-frame SHALL discard partial data; the first capValid after release requires four fresh samples.

Structure
REQ-024 The glyph table constants, FSM state encoding, SETTLE/TIMEOUT defaults SHALL live in shared package display_pkg, usable by the display driver side.
REQ-025 Pattern decoding SHALL be a combinational sub-module seg2hex (in: 7-bit pattern; out: 4-bit number, 1-bit valid), the inverse of hex2seg.

Verification
REQ-026 Drive a display driver with dispVal=16'hBEEF into the block -> capValid pulses, capVal=16'hBEEF, no segError.
REQ-027 Present digit=0100 with segment glitching every 5 cycles (SETTLE=8) -> no sample until stable 8 cycles, then one sample.
REQ-028 Inject pattern 7'b1111111 on nibble 2 of a frame 16'h1234 -> segError pulse, no capValid for that frame, next clean frame captures 16'h1234.
REQ-029 Sample nibbles 0,1,2, stall TIMEOUT cycles, then sample nibble 3 -> no capValid; subsequent full frame captures correctly.
REQ-030 Assert reset after three samples of 16'hA5C3 -> all outputs 0; after release, full frame 16'h0F0F -> capVal=16'h0F0F.
REQ-031 Drive digit=0011 and digit=00010000 -> FSM stays WAIT, no outputs asserted.
